// File: rtl/wb_group_arbiter_if.sv
// Writeback group bundle: per-unit result requests, one-hot accepts and the
// registered group output packet with its downstream ready.
interface wb_group_arbiter_if #(
  parameter int NUM_UNITS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 3,
  parameter int SEL_W      = (NUM_UNITS == 1) ? 1 : $clog2(NUM_UNITS)
);
  logic [NUM_UNITS-1:0]                 unit_done;
  logic [NUM_UNITS-1:0][ID_WIDTH-1:0]   unit_id;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] unit_rd;
  logic [NUM_UNITS-1:0]                 unit_ack;
  logic                                 wb_ready;
  logic                                 wb_valid;
  logic [ID_WIDTH-1:0]                  wb_id;
  logic [DATA_WIDTH-1:0]                wb_data;
  logic [SEL_W-1:0]                     wb_sel;

  modport master (
    output unit_done, unit_id, unit_rd, wb_ready,
    input  unit_ack, wb_valid, wb_id, wb_data, wb_sel
  );

  modport slave (
    input  unit_done, unit_id, unit_rd, wb_ready,
    output unit_ack, wb_valid, wb_id, wb_data, wb_sel
  );
endinterface

// File: rtl/wb_group_arbiter.sv
// Registered arbiter sharing one writeback group port among NUM_UNITS units.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin selection; otherwise lowest index wins.
module wb_group_arbiter #(
  parameter int NUM_UNITS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 3,
  parameter int SEL_W      = (NUM_UNITS == 1) ? 1 : $clog2(NUM_UNITS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  wb_group_arbiter_if.slave bus
);

  logic [SEL_W-1:0]      winner_s;
  logic                  load_s;
  logic [NUM_UNITS-1:0]  ack_s;
  logic                  valid_q, valid_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0]      sel_q, sel_d;

`ifdef WB_ARB_ROUND_ROBIN_EN
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_UNITS - 1);

  logic [SEL_W-1:0] last_grant_q, last_grant_d;
  logic [SEL_W-1:0] idx_s;
  logic             found_s;

  // Round-robin search starting one past the previous winner and wrapping.
  always_comb begin
    winner_s = '0;
    idx_s    = '0;
    found_s  = 1'b0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      idx_s    = SEL_W'((int'(last_grant_q) + 1 + k) % NUM_UNITS);
      winner_s = (bus.unit_done[idx_s] && !found_s) ? idx_s : winner_s;
      found_s  = found_s | bus.unit_done[idx_s];
    end
  end

  // Remember the last winner only when a result is actually taken.
  always_comb begin
    last_grant_d = load_s ? winner_s : last_grant_q;
  end

  // Round-robin pointer register; reset value gives unit 0 first priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q <= LAST_RST;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest requesting index.
  always_comb begin
    winner_s = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      winner_s = bus.unit_done[SEL_W'(i)] ? SEL_W'(i) : winner_s;
    end
  end
`endif

  // A result is taken whenever the output register is free or draining now.
  always_comb begin
    load_s = (|bus.unit_done) && (!valid_q || bus.wb_ready) && !rst_i;
  end

  // One-hot accept to the winner, gated by load.
  always_comb begin
    ack_s           = '0;
    ack_s[winner_s] = load_s;
  end

  // Output register next state: load, drain, or hold under backpressure.
  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (load_s) begin
      valid_d = 1'b1;
      id_d    = bus.unit_id[winner_s];
      data_d  = bus.unit_rd[winner_s];
      sel_d   = winner_s;
    end else if (bus.wb_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output packet register; a held result is dropped on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.unit_ack = ack_s;
  assign bus.wb_valid = valid_q;
  assign bus.wb_id    = id_q;
  assign bus.wb_data  = data_q;
  assign bus.wb_sel   = sel_q;

endmodule

// File: tb/tb_wb_group_arbiter.sv
// Self-checking bench for wb_group_arbiter: a 4-unit and a 1-unit instance,
// expected packets queued at acceptance time and compared when they appear.
module tb_wb_group_arbiter;

`ifdef WB_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        u1;
    logic [31:0] due;
    logic [2:0]  id;
    logic [31:0] data;
    logic [1:0]  sel;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  sb_t  sb_q[$];
  sb_t  mon_e;
  logic [37:0] mon_got, mon_exp;

  logic [2:0]  m_id [4];
  logic [31:0] m_rd [4];

  always #5 clk = ~clk;

  wb_group_arbiter_if #(.NUM_UNITS(4), .DATA_WIDTH(32), .ID_WIDTH(3)) bus4 ();
  wb_group_arbiter_if #(.NUM_UNITS(1), .DATA_WIDTH(32), .ID_WIDTH(3)) bus1 ();

  wb_group_arbiter #(.NUM_UNITS(4), .DATA_WIDTH(32), .ID_WIDTH(3)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .bus(bus4)
  );

  wb_group_arbiter #(.NUM_UNITS(1), .DATA_WIDTH(32), .ID_WIDTH(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1)
  );

  // Scoreboard monitor: pops entries due at this edge and compares the packet.
  always begin
    @(posedge clk);
    cyc++;
    #2;
    while (sb_q.size() != 0 && sb_q[0].due == 32'(cyc)) begin
      mon_e = sb_q.pop_front();
      mon_exp = {1'b1, mon_e.id, mon_e.data, mon_e.sel};
      if (mon_e.u1) mon_got = {bus1.wb_valid, bus1.wb_id, bus1.wb_data, 1'b0, bus1.wb_sel};
      else          mon_got = {bus4.wb_valid, bus4.wb_id, bus4.wb_data, bus4.wb_sel};
      checks++;
      if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL sb_pkt%0s cyc %0d: got valid/id/data/sel=%0b/%0d/%h/%0d required %0b/%0d/%h/%0d",
                 mon_e.u1 ? "_u1" : "_u4", cyc, mon_got[37], mon_got[36:34], mon_got[33:2],
                 mon_got[1:0], mon_exp[37], mon_exp[36:34], mon_exp[33:2], mon_exp[1:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion before 200000");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic u1, input logic [2:0] id, input logic [31:0] data,
                      input logic [1:0] sel);
    sb_t e;
    e.u1 = u1; e.due = 32'(cyc + 1); e.id = id; e.data = data; e.sel = sel;
    sb_q.push_back(e);
  endtask

  task automatic drive_units();
    for (int k = 0; k < 4; k++) begin
      bus4.unit_id[k] = m_id[k];
      bus4.unit_rd[k] = m_rd[k];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus4.unit_done = 4'b1111;
    bus4.wb_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (bus4.unit_ack !== 4'b0000) begin
        errors++; $display("FAIL reset_ack: got %b required 0000", bus4.unit_ack);
      end
      checks++;
      if (bus4.wb_valid !== 1'b0) begin
        errors++; $display("FAIL reset_valid: got %b required 0", bus4.wb_valid);
      end
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus4.unit_ack !== 4'b0001) begin
      errors++; $display("FAIL post_reset_ack: got %b required 0001", bus4.unit_ack);
    end
    push(1'b0, m_id[0], m_rd[0], 2'd0);
    tick();
    bus4.unit_done = 4'b0000;
    @(negedge clk);
    checks++;
    if (bus4.unit_ack !== 4'b0000) begin
      errors++; $display("FAIL idle_ack: got %b required 0000", bus4.unit_ack);
    end
    tick();
    checks++;
    if (bus4.wb_valid !== 1'b0) begin
      errors++; $display("FAIL drain_valid: got %b required 0", bus4.wb_valid);
    end
  endtask

  task automatic test_single();
    m_id[2] = 3'd5;
    m_rd[2] = 32'hDEAD_BEEF;
    drive_units();
    bus4.wb_ready = 1'b1;
    bus4.unit_done = 4'b0100;
    @(negedge clk);
    checks++;
    if (bus4.unit_ack !== 4'b0100) begin
      errors++; $display("FAIL single_ack: got %b required 0100", bus4.unit_ack);
    end
    push(1'b0, 3'd5, 32'hDEAD_BEEF, 2'd2);
    tick();
    bus4.unit_done = 4'b0000;
    tick();
    checks++;
    if (bus4.wb_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain: got %b required 0", bus4.wb_valid);
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp_ack;
    int         exp_w;
    rst = 1'b1;
    bus4.unit_done = 4'b0000;
    tick();
    rst = 1'b0;
    bus4.unit_done = 4'b1111;
    bus4.wb_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      exp_w = RR ? (c % 4) : 0;
      exp_ack = 4'b0001 << exp_w;
      checks++;
      if (bus4.unit_ack !== exp_ack) begin
        errors++; $display("FAIL contention_ack[%0d]: got %b required %b", c, bus4.unit_ack, exp_ack);
      end
      push(1'b0, m_id[exp_w], m_rd[exp_w], 2'(exp_w));
      tick();
    end
    bus4.unit_done = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    bus4.wb_ready = 1'b0;
    bus4.unit_done = 4'b0001;
    @(negedge clk);
    checks++;
    if (bus4.unit_ack !== 4'b0001) begin
      errors++; $display("FAIL bp_first_ack: got %b required 0001", bus4.unit_ack);
    end
    push(1'b0, m_id[0], m_rd[0], 2'd0);
    tick();
    bus4.unit_done = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus4.unit_ack !== 4'b0000) begin
        errors++; $display("FAIL bp_stall_ack[%0d]: got %b required 0000", c, bus4.unit_ack);
      end
      tick();
      checks++;
      if (bus4.wb_valid !== 1'b1 || bus4.wb_sel !== 2'd0 || bus4.wb_data !== m_rd[0]) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid/sel/data=%b/%0d/%h required 1/0/%h",
                 c, bus4.wb_valid, bus4.wb_sel, bus4.wb_data, m_rd[0]);
      end
    end
    bus4.wb_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus4.unit_ack !== 4'b0010) begin
      errors++; $display("FAIL bp_release_ack: got %b required 0010", bus4.unit_ack);
    end
    push(1'b0, m_id[1], m_rd[1], 2'd1);
    tick();
    bus4.unit_done = 4'b1000;
    @(negedge clk);
    checks++;
    if (bus4.unit_ack !== 4'b1000) begin
      errors++; $display("FAIL b2b_ack: got %b required 1000", bus4.unit_ack);
    end
    push(1'b0, m_id[3], m_rd[3], 2'd3);
    tick();
    bus4.unit_done = 4'b0000;
    tick();
    checks++;
    if (bus4.wb_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got %b required 0", bus4.wb_valid);
    end
  endtask

  task automatic test_mid_reset();
    bus4.wb_ready = 1'b0;
    bus4.unit_done = 4'b1000;
    @(negedge clk);
    push(1'b0, m_id[3], m_rd[3], 2'd3);
    tick();
    @(negedge clk);
    checks++;
    if (bus4.unit_ack !== 4'b0000) begin
      errors++; $display("FAIL mr_stall_ack: got %b required 0000", bus4.unit_ack);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus4.unit_ack !== 4'b0000) begin
      errors++; $display("FAIL mr_rst_ack: got %b required 0000", bus4.unit_ack);
    end
    tick();
    checks++;
    if (bus4.wb_valid !== 1'b0 || bus4.wb_sel !== 2'd0) begin
      errors++;
      $display("FAIL mr_rst_out: got valid/sel=%b/%0d required 0/0", bus4.wb_valid, bus4.wb_sel);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus4.unit_ack !== 4'b1000) begin
      errors++; $display("FAIL mr_reack: got %b required 1000", bus4.unit_ack);
    end
    push(1'b0, m_id[3], m_rd[3], 2'd3);
    tick();
    bus4.unit_done = 4'b0000;
    bus4.wb_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_single_unit();
    bus1.unit_done = 1'b1;
    bus1.unit_id = 3'd6;
    bus1.unit_rd = 32'h1234_5678;
    bus1.wb_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus1.unit_ack !== 1'b1) begin
      errors++; $display("FAIL u1_ack0: got %b required 1", bus1.unit_ack);
    end
    push(1'b1, 3'd6, 32'h1234_5678, 2'd0);
    tick();
    bus1.unit_rd = 32'h1234_5679;
    bus1.wb_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus1.unit_ack !== 1'b0) begin
      errors++; $display("FAIL u1_ack1: got %b required 0", bus1.unit_ack);
    end
    tick();
    checks++;
    if (bus1.wb_valid !== 1'b1 || bus1.wb_data !== 32'h1234_5678 || bus1.wb_sel !== 1'b0) begin
      errors++;
      $display("FAIL u1_hold: got valid/data/sel=%b/%h/%0d required 1/12345678/0",
               bus1.wb_valid, bus1.wb_data, bus1.wb_sel);
    end
    bus1.wb_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus1.unit_ack !== 1'b1) begin
      errors++; $display("FAIL u1_ack2: got %b required 1", bus1.unit_ack);
    end
    push(1'b1, 3'd6, 32'h1234_5679, 2'd0);
    tick();
    bus1.unit_done = 1'b0;
    tick();
    checks++;
    if (bus1.wb_valid !== 1'b0) begin
      errors++; $display("FAIL u1_drain: got %b required 0", bus1.wb_valid);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      m_id[k] = 3'(k + 1);
      m_rd[k] = 32'hA000_0000 + 32'(k);
    end
    drive_units();
    bus4.unit_done = 4'b0000;
    bus4.wb_ready = 1'b1;
    bus1.unit_done = 1'b0;
    bus1.unit_id = 3'd0;
    bus1.unit_rd = 32'h0;
    bus1.wb_ready = 1'b1;

    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_mid_reset();
    test_single_unit();
    tick();

    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending entries required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
